preg_free_list: RTL and testbench
=================================

// Module: preg_free_list
// PURPOSE
//  Circular FIFO of free physical-register tags for the rename stage, which sits upstream of the PRF.
//  Rename pops one tag per cycle for each new rd; that tag is then marked not-ready in the PRF.
//  ROB commit pushes back the previous mapping of a retired rd.
//  Committed head pointer gives single-cycle recovery on a branch mispredict.
// PARAMETERS
//  NUM_PREGS  128  physical registers in PRF
//  NUM_AREGS  32   architectural regs; pregs 0..NUM_AREGS-1 mapped at reset, never initially free
//  TAG_W      7    tag width, = $clog2(NUM_PREGS)
//  DEPTH      96   FIFO entries, = NUM_PREGS-NUM_AREGS (derived, not overridden)
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high
//  alloc_req     in   1      rename needs a tag this cycle
//  alloc_gnt     out  1      tag popped this cycle (comb)
//  alloc_tag     out  TAG_W  tag at spec head (comb peek, valid when !empty)
//  empty         out  1      no free tag (comb from pointers)
//  free_cnt      out  TAG_W  number of free tags, 0..DEPTH (comb)
//  commit_alloc  in   1      retiring insn had an rd; advances committed head by 1
//  free_valid    in   1      push free_tag (old mapping of retiring rd)
//  free_tag      in   TAG_W  tag being returned
//  recover       in   1      mispredict flush; restore spec head to committed head
//  overflow_err  out  1      sticky: free pushed while full or tag==0 pushed
// BEHAVIOUR
//  Storage: mem[DEPTH] of TAG_W. Pointers spec_head, cmt_head, tail are each $clog2(DEPTH)+1 bits.
//   Wrap: index wraps at DEPTH-1 -> 0 and the extra MSB toggles on each wrap.
//  Reset (async): mem[i]=NUM_AREGS+i; spec_head=cmt_head=0; tail=DEPTH with MSB=1 (full).
//   Resulting outputs: alloc_tag=32, free_cnt=96, empty=0, alloc_gnt=0, overflow_err=0.
//  Counts: free_cnt = tail - spec_head (wrap-aware). empty = (free_cnt==0).
//  Alloc:
//   - alloc_gnt = alloc_req & !empty & !recover.
//   - On alloc_gnt, spec_head++ at the clock edge; zero-latency peek, so alloc_tag is usable the same cycle.
//   - Empty is evaluated before a same-cycle free; a tag freed at cycle N is allocatable from cycle N+1.
//  Free:
//   - On free_valid & full (tail - cmt_head == DEPTH): drop the push, set overflow_err.
//   - On free_valid & free_tag==0: drop the push, set overflow_err (x0's preg is never recycled).
//   - Otherwise write mem[tail]=free_tag and tail++.
//   - Fullness is measured against cmt_head, so in-flight speculative allocations still hold their slots.
//  Commit: commit_alloc -> cmt_head++.
//   - Precondition: cmt_head != spec_head. Violation is an assertion failure, not recovered.
//  Recover: spec_head <= cmt_head (or cmt_head+1 if commit_alloc is also high).
//   - alloc_gnt is forced to 0 in that cycle.
//   - free_valid and commit_alloc in the same cycle are still honoured, since they come from older insns.
//  Simultaneous alloc+free: both occur; free_cnt is unchanged next cycle.
//  overflow_err clears only on reset.
//  Reset asserted mid-operation: all state returns to reset values immediately.
//  No stall output beyond empty; the upstream rename stage must hold alloc_req until it sees alloc_gnt.
// TESTING
//  1. Reset, hold alloc_req 96 cycles -> tags 32..127 in order; empty=1 at cycle 96; alloc_gnt=0 after that.
//  2. From empty: free_valid tag=45 at cycle N with alloc_req high -> gnt=0 at N; gnt=1, alloc_tag=45 at N+1.
//  3. Alloc 5 (32..36), commit_alloc 2, recover -> alloc_tag=34, free_cnt=94.
//  4. Recover + commit_alloc + free_valid(tag 40) in one cycle -> spec_head=cmt_head+1, tag 40 at tail, gnt=0.
//  5. At reset (full), free_valid tag=50 -> overflow_err=1, free_cnt stays 96; free_tag=0 also sets it.
//  6. Random alloc/free/commit/recover for 10k cycles; scoreboard checks:
//     - no duplicate tag is ever live;
//     - free_cnt plus live-allocated count always equals 96;
//     - pointer wrap is exercised at least 3 times.

Source files
------------

// File: rtl/preg_free_list.sv
// preg_free_list
//   Circular FIFO of free physical-register tags for the rename stage.
//   Rename pops one tag per cycle from the speculative head. ROB commit
//   advances a second, committed head and pushes back the retired rd's old
//   mapping at the tail. A branch mispredict restores the speculative head
//   from the committed head in a single cycle.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high
//   alloc_req     rename needs a tag this cycle
//   alloc_gnt     a tag is popped this cycle (combinational)
//   alloc_tag     tag at the speculative head (combinational peek)
//   empty         no free tag available to rename
//   free_cnt      number of free tags, measured from the speculative head
//   commit_alloc  retiring instruction had an rd; advances the committed head
//   free_valid    push free_tag back into the list
//   free_tag      tag being returned
//   recover       mispredict flush; speculative head <= committed head
//   overflow_err  sticky: push while full, or push of tag 0
module preg_free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             empty,
  output logic [TAG_W-1:0] free_cnt,
  input  logic             commit_alloc,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             recover,
  output logic             overflow_err
);

  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // DEPTH need not be a power of two, so the index wraps explicitly at
  // DEPTH-1 and the MSB acts as a lap bit that toggles on every wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
      return {~p[PTR_W-1], {IDX_W{1'b0}}};
    end
    return {p[PTR_W-1], p[IDX_W-1:0] + IDX_W'(1)};
  endfunction

  // Occupancy between a leading and a trailing pointer; when the lap bits
  // differ the leading pointer is one full lap ahead.
  function automatic logic [CNT_W-1:0] ptr_diff(input ptr_t lead, input ptr_t trail);
    if (lead[PTR_W-1] == trail[PTR_W-1]) begin
      return {1'b0, lead[IDX_W-1:0]} - {1'b0, trail[IDX_W-1:0]};
    end
    return CNT_W'(DEPTH) + {1'b0, lead[IDX_W-1:0]} - {1'b0, trail[IDX_W-1:0]};
  endfunction

  ptr_t             spec_head_q, spec_head_d;
  ptr_t             cmt_head_q, cmt_head_d;
  ptr_t             tail_q, tail_d;
  logic             overflow_err_q, overflow_err_d;
  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];

  logic [CNT_W-1:0] spec_cnt;
  logic [CNT_W-1:0] cmt_cnt;
  logic             full;
  logic             bad_push;
  logic             push;

  // Fullness is judged from the committed head so that slots holding
  // in-flight speculative allocations cannot be overwritten by a push.
  always_comb begin
    spec_cnt  = ptr_diff(tail_q, spec_head_q);
    cmt_cnt   = ptr_diff(tail_q, cmt_head_q);
    empty     = (spec_cnt == '0);
    full      = (cmt_cnt == CNT_W'(DEPTH));
    alloc_gnt = alloc_req & ~empty & ~recover;
    alloc_tag = mem_q[spec_head_q[IDX_W-1:0]];
    free_cnt  = TAG_W'(spec_cnt);
    bad_push  = free_valid & (full | (free_tag == '0));
    push      = free_valid & ~bad_push;
    overflow_err = overflow_err_q;
  end

  // Recovery reloads the speculative head from the already-updated committed
  // head, so a commit in the same cycle is accounted for.
  always_comb begin
    cmt_head_d = commit_alloc ? ptr_inc(cmt_head_q) : cmt_head_q;
    if (recover) begin
      spec_head_d = cmt_head_d;
    end else if (alloc_gnt) begin
      spec_head_d = ptr_inc(spec_head_q);
    end else begin
      spec_head_d = spec_head_q;
    end
    tail_d         = push ? ptr_inc(tail_q) : tail_q;
    overflow_err_d = overflow_err_q | bad_push;
    mem_d          = mem_q;
    if (push) begin
      mem_d[tail_q[IDX_W-1:0]] = free_tag;
    end
  end

  // At reset every non-architectural preg is free: the list holds
  // NUM_AREGS..NUM_PREGS-1 in order and the tail sits one full lap ahead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_head_q    <= '0;
      cmt_head_q     <= '0;
      tail_q         <= {1'b1, {IDX_W{1'b0}}};
      overflow_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TAG_W'(NUM_AREGS + i);
      end
    end else begin
      spec_head_q    <= spec_head_d;
      cmt_head_q     <= cmt_head_d;
      tail_q         <= tail_d;
      overflow_err_q <= overflow_err_d;
      mem_q          <= mem_d;
    end
  end

  // Committing more allocations than were made is an upstream bug.
  commit_behind_spec: assert property (@(posedge clk) disable iff (reset)
    commit_alloc |-> (cmt_head_q != spec_head_q));

endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list
//   Directed vector table plus hand-written multi-cycle sequences and a
//   randomized scoreboard run for preg_free_list.
module tb_preg_free_list;

  logic       clk;
  logic       reset;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [6:0] alloc_tag;
  logic       empty;
  logic [6:0] free_cnt;
  logic       commit_alloc;
  logic       free_valid;
  logic [6:0] free_tag;
  logic       recover;
  logic       overflow_err;

  int checks   = 0;
  int failures = 0;

  preg_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag    (alloc_tag),
    .empty        (empty),
    .free_cnt     (free_cnt),
    .commit_alloc (commit_alloc),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .recover      (recover),
    .overflow_err (overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int req;
    int cm;
    int fv;
    int ft;
    int rc;
    int gnt;
    int tag;
    int emp;
    int cnt;
    int ovf;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic apply_stimulus(input int req, input int cm, input int fv, input int ft, input int rc);
    @(negedge clk);
    alloc_req    = (req != 0);
    commit_alloc = (cm != 0);
    free_valid   = (fv != 0);
    free_tag     = 7'(ft);
    recover      = (rc != 0);
    #1;
  endtask

  // A negative expected tag means the tag is not checked.
  task automatic check_output(input string pfx, input int g, input int t, input int e, input int c, input int o);
    check({pfx, " gnt"}, 32'(alloc_gnt), g);
    if (t >= 0) check({pfx, " tag"}, 32'(alloc_tag), t);
    check({pfx, " empty"}, 32'(empty), e);
    check({pfx, " free_cnt"}, 32'(free_cnt), c);
    check({pfx, " overflow"}, 32'(overflow_err), o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_req = 1'b0; commit_alloc = 1'b0; free_valid = 1'b0; free_tag = '0; recover = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset raised between edges must take effect without a clock edge.
  task automatic reset_midop();
    @(negedge clk);
    alloc_req = 1'b0; commit_alloc = 1'b0; free_valid = 1'b0; free_tag = '0; recover = 1'b0;
    #2 reset = 1'b1;
    #1 check_output("midrst", 0, 32, 0, 96, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard state for the random run: unbounded integer pointers.
  int m_mem [96];
  int m_spec, m_cmt, m_tail;
  bit live [128];
  int inflight [$];
  int pool [$];
  int wraps;

  initial begin
    reset = 1'b1;
    alloc_req = 1'b0; commit_alloc = 1'b0; free_valid = 1'b0; free_tag = '0; recover = 1'b0;

    //             req cm fv  ft rc  gnt tag emp cnt ovf
    vecs[0]  = '{  0, 0, 0,  0, 0,  0, 32, 0, 96, 0};
    vecs[1]  = '{  0, 0, 1, 50, 0,  0, 32, 0, 96, 0};
    vecs[2]  = '{  0, 0, 0,  0, 0,  0, 32, 0, 96, 1};
    vecs[3]  = '{  1, 0, 0,  0, 0,  1, 32, 0, 96, 1};
    vecs[4]  = '{  1, 0, 0,  0, 0,  1, 33, 0, 95, 1};
    vecs[5]  = '{  1, 0, 0,  0, 0,  1, 34, 0, 94, 1};
    vecs[6]  = '{  1, 0, 0,  0, 0,  1, 35, 0, 93, 1};
    vecs[7]  = '{  1, 0, 0,  0, 0,  1, 36, 0, 92, 1};
    vecs[8]  = '{  0, 1, 0,  0, 0,  0, 37, 0, 91, 1};
    vecs[9]  = '{  0, 1, 0,  0, 0,  0, 37, 0, 91, 1};
    vecs[10] = '{  1, 0, 0,  0, 1,  0, 37, 0, 91, 1};
    vecs[11] = '{  0, 0, 0,  0, 0,  0, 34, 0, 94, 1};
    vecs[12] = '{  1, 0, 1, 32, 0,  1, 34, 0, 94, 1};
    vecs[13] = '{  0, 0, 0,  0, 0,  0, 35, 0, 94, 1};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].cm, vecs[i].fv, vecs[i].ft, vecs[i].rc);
      check_output($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].tag, vecs[i].emp, vecs[i].cnt, vecs[i].ovf);
    end

    // Drain the whole list in order, then confirm empty blocks grants.
    do_reset();
    for (int i = 0; i < 96; i++) begin
      apply_stimulus(1, 0, 0, 0, 0);
      check_output($sformatf("drain%0d", i), 1, 32 + i, 0, 96 - i, 0);
    end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 0, 0, 0, 0);
      check_output($sformatf("drained%0d", i), 0, -1, 1, 0, 0);
    end

    // From empty: a freed tag becomes allocatable one cycle later.
    repeat (5) apply_stimulus(0, 1, 0, 0, 0);
    apply_stimulus(1, 0, 1, 45, 0);
    check_output("refill_n", 0, -1, 1, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("refill_n1", 1, 45, 0, 1, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("tag0_push", 0, -1, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("tag0_after", 0, -1, 1, 0, 1);

    reset_midop();

    // Recover, commit and free all in one cycle.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 0, 0, 0);
      check_output($sformatf("combo_alloc%0d", i), 1, 32 + i, 0, 96 - i, 0);
    end
    apply_stimulus(0, 1, 0, 0, 0);
    check_output("combo_commit", 0, 35, 0, 93, 0);
    apply_stimulus(1, 1, 1, 40, 1);
    check_output("combo_cycle", 0, 35, 0, 93, 0);
    for (int i = 0; i < 94; i++) begin
      apply_stimulus(1, 0, 0, 0, 0);
      check_output($sformatf("combo_walk%0d", i), 1, 34 + i, 0, 95 - i, 0);
    end
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("combo_tail40", 1, 40, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("combo_end", 0, -1, 1, 0, 0);

    // Random alloc/free/commit/recover against the scoreboard.
    do_reset();
    for (int i = 0; i < 96; i++) m_mem[i] = 32 + i;
    for (int i = 0; i < 128; i++) live[i] = 1'b0;
    m_spec = 0; m_cmt = 0; m_tail = 96; wraps = 0;
    inflight.delete(); pool.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int req, rc, cm, fv, ft, k, live_n, exp_cnt, exp_emp, exp_g, t;
      live_n = inflight.size() + pool.size();
      req = ($urandom_range(0, 99) < 60) ? 1 : 0;
      rc  = ($urandom_range(0, 99) < 3) ? 1 : 0;
      cm  = (inflight.size() > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
      fv  = (pool.size() > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
      ft  = 0;
      if (fv != 0) begin
        k  = $urandom_range(0, pool.size() - 1);
        ft = pool[k];
        pool.delete(k);
      end
      apply_stimulus(req, cm, fv, ft, rc);
      exp_cnt = m_tail - m_spec;
      exp_emp = (exp_cnt == 0) ? 1 : 0;
      exp_g   = (req != 0 && exp_emp == 0 && rc == 0) ? 1 : 0;
      check_output("rnd", exp_g, (exp_emp != 0) ? -1 : m_mem[m_spec % 96], exp_emp, exp_cnt, 0);
      check("rnd invariant", 32'(free_cnt) + live_n, 96);
      if (exp_g != 0) begin
        t = m_mem[m_spec % 96];
        check("rnd duplicate", 32'(live[t]), 0);
        live[t] = 1'b1;
        inflight.push_back(t);
        if (m_spec % 96 == 95) wraps++;
        m_spec++;
      end
      if (fv != 0) begin
        m_mem[m_tail % 96] = ft;
        m_tail++;
        live[ft] = 1'b0;
      end
      if (cm != 0) begin
        pool.push_back(inflight.pop_front());
        m_cmt++;
      end
      if (rc != 0) begin
        m_spec = m_cmt;
        foreach (inflight[j]) live[inflight[j]] = 1'b0;
        inflight.delete();
      end
    end
    check("rnd wraps>=3", (wraps >= 3) ? 32'd1 : 32'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
